instr_fetch_unit: RTL

//  Fetch stage directly upstream of the sign extender and decode logic. Holds the PC and

---
 rtl/instr_fetch_unit_if.sv | 29 ++
 rtl/instr_fetch_unit.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, the decode-side
// valid/ready buffer and the branch redirect inputs.
interface instr_fetch_unit_if #(
    parameter int AW = 64
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [31:0]   imem_rdata;
    logic          instr_valid;
    logic [31:0]   instr;
    logic [AW-1:0] instr_pc;
    logic          instr_ready;
    logic          br_taken;
    logic [AW-1:0] br_pc;
    logic [AW-1:0] br_offset;

    // Fetch unit side
    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_ack, imem_rdata, instr_ready, br_taken, br_pc, br_offset
    );

    // Environment side: memory, decode and branch resolution
    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_ack, imem_rdata, instr_ready, br_taken, br_pc, br_offset
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: holds the PC, issues one request at a time to a
// variable-latency instruction memory, buffers one word for decode and
// redirects on taken branches (target = br_pc + br_offset, wrapping).
// A redirect while a request is in flight cannot withdraw it, so the stale
// response is drained and dropped before fetching the new target.
module instr_fetch_unit #(
    parameter int AW      = 64,
    parameter int PC_STEP = 4
) (
    input  logic                CLK,
    input  logic                resetl,
    input  logic [AW-1:0]       startpc,
    instr_fetch_unit_if.master  bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam logic [AW-1:0] PC_INC = AW'(PC_STEP);

    logic [1:0]    state_r;
    logic [AW-1:0] pc_r;
    logic [AW-1:0] req_addr_r;
    logic          req_r;
    logic          valid_r;
    logic [31:0]   instr_r;
    logic [AW-1:0] instr_pc_r;

    logic [1:0]    state_s;
    logic [AW-1:0] pc_s;
    logic [AW-1:0] req_addr_s;
    logic          req_s;
    logic          valid_s;
    logic [31:0]   instr_s;
    logic [AW-1:0] instr_pc_s;
    logic [AW-1:0] target_s;
    logic [AW-1:0] pc_inc_s;

    // Next-state and datapath decisions; a branch outranks every other event
    always_comb begin
        target_s   = bus.br_pc + bus.br_offset;
        pc_inc_s   = pc_r + PC_INC;
        state_s    = state_r;
        pc_s       = pc_r;
        req_addr_s = req_addr_r;
        valid_s    = valid_r;
        instr_s    = instr_r;
        instr_pc_s = instr_pc_r;

        case (state_r)
            ST_IDLE: begin
                state_s = ST_FETCH;
                if (bus.br_taken) begin
                    pc_s       = target_s;
                    req_addr_s = target_s;
                end else begin
                    req_addr_s = pc_r;
                end
            end
            ST_FETCH: begin
                if (bus.br_taken) begin
                    pc_s = target_s;
                    if (bus.imem_ack) begin
                        // Response arrives with the redirect: drop it, fetch target now
                        req_addr_s = target_s;
                        state_s    = ST_FETCH;
                    end else begin
                        // Request stays on the bus; its response must be discarded
                        state_s = ST_DRAIN;
                    end
                end else if (bus.imem_ack) begin
                    instr_s    = bus.imem_rdata;
                    instr_pc_s = req_addr_r;
                    valid_s    = 1'b1;
                    state_s    = ST_HOLD;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (bus.br_taken) begin
                    valid_s    = 1'b0;
                    pc_s       = target_s;
                    req_addr_s = target_s;
                    state_s    = ST_FETCH;
                end else if (bus.instr_ready) begin
                    valid_s    = 1'b0;
                    pc_s       = pc_inc_s;
                    req_addr_s = pc_inc_s;
                    state_s    = ST_FETCH;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            ST_DRAIN: begin
                if (bus.br_taken) begin
                    // Latest redirect wins; the old request is still outstanding
                    pc_s    = target_s;
                    state_s = ST_DRAIN;
                end else if (bus.imem_ack) begin
                    req_addr_s = pc_r;
                    state_s    = ST_FETCH;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_IDLE;
                valid_s = 1'b0;
            end
        endcase

        req_s = (state_s == ST_FETCH) || (state_s == ST_DRAIN);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!resetl) begin
            state_r    <= ST_IDLE;
            pc_r       <= startpc;
            req_addr_r <= startpc;
            req_r      <= 1'b0;
            valid_r    <= 1'b0;
            instr_r    <= 32'd0;
            instr_pc_r <= {AW{1'b0}};
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            req_addr_r <= req_addr_s;
            req_r      <= req_s;
            valid_r    <= valid_s;
            instr_r    <= instr_s;
            instr_pc_r <= instr_pc_s;
        end
    end

    assign bus.imem_req    = req_r;
    assign bus.imem_addr   = req_addr_r;
    assign bus.instr_valid = valid_r;
    assign bus.instr       = instr_r;
    assign bus.instr_pc    = instr_pc_r;

endmodule
